// File: rtl/ready_valid_arbiter.sv
// ready_valid_arbiter: round-robin N:1 merge of ready/valid streams
// behind a registered output slice (data, valid, source id).
module ready_valid_arbiter #(
  parameter int NUM_INTERFACES = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int ID_WIDTH       =
    (NUM_INTERFACES > 1) ? $clog2(NUM_INTERFACES) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_INTERFACES-1:0]          in_valid,
  output logic [NUM_INTERFACES-1:0]          in_ready,
  input  logic [NUM_INTERFACES*DATA_WIDTH-1:0] in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [ID_WIDTH-1:0]                out_id
);

  localparam int N = NUM_INTERFACES;

  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   gid;
  logic [ID_WIDTH-1:0]   ptr_nxt;
  logic [N-1:0]          grant;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  found;
  logic                  load_en;
  logic                  take;

  // Slot is free when empty or when the held beat drains this cycle.
  always_comb load_en = !out_valid || out_ready;

  // Search positions ptr, ptr+1, .. with wrap; first valid wins.
  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && in_valid[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + N))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          gid      = ID_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    if (int'(gid) == N - 1) ptr_nxt = '0;
    else                    ptr_nxt = gid + 1'b1;
  end

  // Ready is held low during reset so no beat is consumed and then dropped.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en) in_ready = grant;
  end

  always_comb take = load_en && found;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= found;
      if (take) begin
        out_data <= sel_data;
        out_id   <= gid;
        ptr      <= ptr_nxt;
      end
    end
  end

  a_ready_onehot: assert property (
    @(posedge clk) $onehot0(in_ready));

  a_out_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) && $stable(out_id)));

endmodule

// File: tb/tb_ready_valid_arbiter.sv
// tb_ready_valid_arbiter: N=4, N=3 and N=1 instances driven together
// against a queue-based round-robin reference model.
module tb_ready_valid_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         nn[3] = '{4, 3, 1};
  logic [3:0] iv[3];
  logic [7:0] idat[3][4];
  logic       ordy[3];

  logic [3:0]  v4, r4;
  logic [31:0] d4;
  logic        ov4;
  logic [7:0]  od4;
  logic [1:0]  id4;
  logic [2:0]  v3, r3;
  logic [23:0] d3;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  id3;
  logic        v1, r1;
  logic [7:0]  d1;
  logic        ov1;
  logic [7:0]  od1;
  logic [0:0]  id1;

  assign v4 = iv[0];
  assign d4 = {idat[0][3], idat[0][2], idat[0][1], idat[0][0]};
  assign v3 = iv[1][2:0];
  assign d3 = {idat[1][2], idat[1][1], idat[1][0]};
  assign v1 = iv[2][0];
  assign d1 = idat[2][0];

  ready_valid_arbiter #(.NUM_INTERFACES(4), .DATA_WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .in_ready(r4), .in_data(d4),
    .out_valid(ov4), .out_ready(ordy[0]),
    .out_data(od4), .out_id(id4));

  ready_valid_arbiter #(.NUM_INTERFACES(3), .DATA_WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v3), .in_ready(r3), .in_data(d3),
    .out_valid(ov3), .out_ready(ordy[1]),
    .out_data(od3), .out_id(id3));

  ready_valid_arbiter #(.NUM_INTERFACES(1), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(r1), .in_data(d1),
    .out_valid(ov1), .out_ready(ordy[2]),
    .out_data(od1), .out_id(id1));

  function automatic logic [3:0] obs_rdy(int d);
    case (d)
      0:       return r4;
      1:       return {1'b0, r3};
      default: return {3'b0, r1};
    endcase
  endfunction

  function automatic logic obs_ov(int d);
    case (d)
      0:       return ov4;
      1:       return ov3;
      default: return ov1;
    endcase
  endfunction

  function automatic logic [7:0] obs_od(int d);
    case (d)
      0:       return od4;
      1:       return od3;
      default: return od1;
    endcase
  endfunction

  function automatic logic [1:0] obs_id(int d);
    case (d)
      0:       return id4;
      1:       return id3;
      default: return {1'b0, id1};
    endcase
  endfunction

  // Reference: next-to-serve pointer plus one held beat per instance.
  int         mptr[3];
  bit         mv[3];
  logic [7:0] md[3];
  int         mid[3];
  logic [7:0] sbq[3][4][$];

  task automatic cycle();
    #1;
    for (int d = 0; d < 3; d++) begin
      int  n;
      int  g;
      bit  load;
      logic [1:0] oid;
      n    = nn[d];
      load = !mv[d] || ordy[d];
      g    = -1;
      if (load) begin
        for (int k = 0; k < n; k++) begin
          int i;
          i = (mptr[d] + k) % n;
          if (g < 0 && iv[d][i]) g = i;
        end
      end
      check($sformatf("ready_n%0d", n), obs_rdy(d),
            (g >= 0) ? (32'(1) << g) : 32'(0));
      check($sformatf("valid_n%0d", n), obs_ov(d), mv[d]);
      if (mv[d]) begin
        check($sformatf("data_n%0d", n), obs_od(d), md[d]);
        check($sformatf("id_n%0d", n), obs_id(d), mid[d]);
      end
      if (mv[d] && ordy[d]) begin
        oid = obs_id(d);
        if (sbq[d][oid].size() == 0)
          check($sformatf("sb_empty_n%0d", n), 1, 0);
        else
          check($sformatf("sb_order_n%0d", n), obs_od(d),
                sbq[d][oid].pop_front());
      end
      if (load) begin
        if (g >= 0) begin
          mv[d]   = 1'b1;
          md[d]   = idat[d][g];
          mid[d]  = g;
          mptr[d] = (g + 1) % n;
          sbq[d][g].push_back(idat[d][g]);
        end else begin
          mv[d] = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ready_n%0d", nn[d]), obs_rdy(d), 0);
      mptr[d] = 0;
      mv[d]   = 1'b0;
      md[d]   = '0;
      mid[d]  = 0;
      for (int i = 0; i < 4; i++) sbq[d][i].delete();
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_valid_n%0d", nn[d]), obs_ov(d), 0);
      check($sformatf("rst_data_n%0d", nn[d]), obs_od(d), 0);
      check($sformatf("rst_id_n%0d", nn[d]), obs_id(d), 0);
    end
    rst_n = 1'b1;
  endtask

  task automatic idle();
    for (int d = 0; d < 3; d++) begin
      iv[d]   = '0;
      ordy[d] = 1'b1;
      for (int i = 0; i < 4; i++) idat[d][i] = 8'(16 * d + i + 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    for (int d = 0; d < 3; d++) iv[d] = 4'hF;
    do_reset();

    // single requester on in[2]
    idle();
    iv[0]       = 4'b0100;
    idat[0][2]  = 8'hA5;
    #1 check("t1_ready", r4, 4'b0100);
    cycle();
    check("t1_valid", ov4, 1);
    check("t1_data", od4, 8'hA5);
    check("t1_id", id4, 2);
    iv[0] = 4'hF;
    cycle();
    check("t1_ptr_next", id4, 3);

    // all valid, full throughput
    do_reset();
    idle();
    iv[0] = 4'hF;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 4; i++) idat[0][i] = 8'($urandom);
      cycle();
      check("t2_valid", ov4, 1);
      check("t2_id", id4, 32'(j % 4));
    end

    // backpressure after first beat
    do_reset();
    idle();
    iv[0] = 4'hF;
    cycle();
    ordy[0] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      idat[0][j % 4] = 8'($urandom);
      #1 check("t3_ready_low", r4, 0);
      cycle();
      check("t3_hold_id", id4, 0);
      check("t3_hold_valid", ov4, 1);
    end
    ordy[0] = 1'b1;
    #1 check("t3_resume_ready", r4, 4'b0010);
    cycle();
    check("t3_resume_id", id4, 1);

    // N=3, ptr=1, in[1] idle
    do_reset();
    idle();
    iv[1] = 4'b001;
    cycle();
    check("t4_first", id3, 0);
    iv[1] = 4'b101;
    cycle();
    check("t4_g2", id3, 2);
    cycle();
    check("t4_g0", id3, 0);
    cycle();
    check("t4_g2b", id3, 2);

    // reset while stalled
    do_reset();
    idle();
    iv[0]   = 4'hF;
    ordy[0] = 1'b0;
    cycle();
    cycle();
    check("t5_stalled", ov4, 1);
    do_reset();
    iv[0]   = 4'b0110;
    ordy[0] = 1'b1;
    cycle();
    check("t5_lowest", id4, 1);

    // random traffic on all instances
    do_reset();
    for (int j = 0; j < 1500; j++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d]   = 4'($urandom) & 4'((1 << nn[d]) - 1);
        ordy[d] = 1'($urandom);
        for (int i = 0; i < 4; i++) idat[d][i] = 8'($urandom);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
